uart_report_gen: RTL
====================

Name: uart_report_gen

Overview:
Parametrised periodic UART report formatter for the N-channel voltage instrument. It replaces fixed-format text generation with a configurable channel count, digit count and report period. Each frame carries one ASCII line per channel. It talks to the UART transmitter through a proper valid/ready handshake, not a fixed tick. It sits between the per-channel BCD voltage registers and uart_tx.

Parameters:
N_CH, 13, number of channels reported per frame (1..99)
DIGITS, 4, BCD digits per channel value (1..8)
PERIOD, 100_000_000, clk cycles between automatic frame triggers (>=2)
UNIT_CHAR, 8'h56, ASCII unit suffix and line prefix ('V')

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
ch_data  in  N_CH*DIGITS*4  packed BCD; channel k (1-based) at [k*DIGITS*4-1 -: DIGITS*4], MS digit in the top nibble
force_start  in  1  single-cycle request for an immediate frame
tx_data  out  8  ASCII character to the transmitter
tx_valid  out  1  tx_data is valid
tx_ready  in  1  transmitter accepts tx_data this cycle
busy  out  1  frame in progress (LOAD or SEND)
frame_done  out  1  one-cycle pulse after the last character of a frame is accepted

Behaviour:
- Reset: tx_data=0, tx_valid=0, busy=0, frame_done=0, period counter=0, pending=0, FSM=IDLE. Reset asserted mid-frame aborts the frame immediately; no residual tx_valid on the next cycle.
- Period counter runs free in every state. It wraps 0..PERIOD-1. Reaching PERIOD-1 raises trigger for one cycle. force_start also raises trigger.
- Trigger in IDLE: go to LOAD next cycle. Trigger while busy: set pending (saturates at one). Extra triggers are dropped. When the frame ends and pending=1, go IDLE->LOAD on the following cycle and clear pending.
- States:
  - IDLE: wait for trigger or pending.
  - LOAD: snapshot all of ch_data into an internal register, set channel index=1, set char index=0. Changes to ch_data during SEND do not affect the frame.
  - SEND: present characters one at a time. Return to IDLE after the last character is accepted.
- Line format per channel, L=DIGITS+10 characters:
  - UNIT_CHAR, then channel tens and units digits as ASCII ('0'+n).
  - ' ' '-' ' '.
  - DIGITS value digits, MS first.
  - ' ', UNIT_CHAR, 8'h0A, 8'h0D.
  - Frame length is N_CH*L characters.
- Digit conversion: a nibble of 0..9 becomes 8'h30+nibble. A nibble of 10..15 becomes '?' (8'h3F).
- Latency: trigger at cycle T -> LOAD at T+1 -> tx_valid=1 with the first character at T+2.
- Handshake:
  - Transfer occurs on any rising edge where tx_valid & tx_ready are both high.
  - tx_data is stable while tx_valid=1 and tx_ready=0.
  - After a non-final transfer, tx_valid stays 1 and tx_data shows the next character on the next cycle, so back-to-back transfers run at one char per clk.
  - After the final transfer, tx_valid=0 and frame_done=1 on the next cycle.
  - tx_ready while tx_valid=0 is ignored.
- busy=1 from LOAD through the cycle frame_done is high.
- Counter widths are $clog2-sized from the parameters. The channel index compares against N_CH and the char index against L-1 for wrap. No overflow is possible.

Test Plan:
- N_CH=2, DIGITS=4, PERIOD=50, tx_ready=1, ch1=16'h1234, ch2=16'h0987:
  - first trigger at cycle 49; tx_valid rises at cycle 51.
  - bytes 56 30 31 20 2D 20 31 32 33 34 20 56 0A 0D, then 56 30 32 20 2D 20 30 39 38 37 20 56 0A 0D.
  - 28 consecutive transfers, then frame_done for one cycle and busy=0.
- Backpressure: tx_ready toggles with a random duty cycle.
  - tx_data is unchanged across every stalled cycle.
  - The byte sequence is identical to the previous test.
- Invalid BCD: ch1=16'h1A3F -> value digits sent as 31 3F 33 3F.
- force_start pulsed mid-frame, plus a period trigger in the same frame:
  - exactly one extra frame starts at frame_done+1 (LOAD).
  - a third trigger is dropped.
- ch_data changed during SEND: the frame still carries the LOAD snapshot.
- rst pulsed for one cycle after the 5th byte:
  - next cycle tx_valid=0, busy=0, counter=0.
  - the next frame starts at cycle 49 after reset is released.

Source files
------------

// File: rtl/uart_report_gen.sv
// Periodic UART report formatter: one ASCII line per channel, N_CH lines per frame.
// Latency: trigger at cycle T -> LOAD at T+1 -> first character valid at T+2.
// Backpressure: valid/ready to the transmitter, and tx_data holds while tx_ready is low.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   ch_data           packed BCD, channel k at [k*DIGITS*4-1 -: DIGITS*4], MS digit on top
//   force_start       single-cycle request for an immediate frame
//   tx_data/tx_valid  character stream to uart_tx, accepted when tx_ready is high
//   busy              high from LOAD through the frame_done cycle
//   frame_done        one-cycle pulse after the last character is accepted
//
// Line layout (L = DIGITS+10): U t u ' ' '-' ' ' d..d ' ' U LF CR
module uart_report_gen #(
  parameter int          N_CH      = 13,
  parameter int          DIGITS    = 4,
  parameter int          PERIOD    = 100_000_000,
  parameter logic [7:0]  UNIT_CHAR = 8'h56
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CH*DIGITS*4-1:0]  ch_data,
  input  logic                      force_start,
  output logic [7:0]                tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int L     = DIGITS + 10;
  localparam int DW    = N_CH * DIGITS * 4;
  localparam int CNT_W = $clog2(PERIOD);
  localparam int CH_W  = $clog2(N_CH + 1);
  localparam int CI_W  = $clog2(L);

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  state_t            state;
  logic [CNT_W-1:0]  period_cnt;
  logic              pending;
  logic [DW-1:0]     snap;
  logic [CH_W-1:0]   ch_idx;
  logic [CI_W-1:0]   char_idx;

  logic              trigger;
  logic              xfer;
  logic              last_char;
  logic              last_ch;
  logic [CH_W-1:0]   nxt_ch;
  logic [CI_W-1:0]   nxt_ci;

  // 0..9 map to ASCII digits; anything else is shown as '?'.
  function automatic logic [7:0] digit_char(input logic [3:0] n);
    if (n <= 4'd9) return 8'h30 + {4'h0, n};
    else           return 8'h3F;
  endfunction

  // Character at position ci of the line for channel ch (1-based), taken from d.
  function automatic logic [7:0] line_char(input logic [CH_W-1:0] ch,
                                           input logic [CI_W-1:0] ci,
                                           input logic [DW-1:0]   d);
    int            c;
    int            i;
    int            pos;
    logic [DW-1:0] sh;
    c = 32'(ch);
    i = 32'(ci);
    if (i == 0)                return UNIT_CHAR;
    else if (i == 1)           return 8'h30 + 8'(c / 10);
    else if (i == 2)           return 8'h30 + 8'(c % 10);
    else if (i == 3 || i == 5) return 8'h20;
    else if (i == 4)           return 8'h2D;
    else if (i == L - 4)       return 8'h20;
    else if (i == L - 3)       return UNIT_CHAR;
    else if (i == L - 2)       return 8'h0A;
    else if (i == L - 1)       return 8'h0D;
    else begin
      // value digit (i-6) counted from the MS nibble of this channel's field
      pos = (c - 1) * DIGITS + (DIGITS - 1 - (i - 6));
      sh  = d >> (pos * 4);
      return digit_char(sh[3:0]);
    end
  endfunction

  assign trigger = (period_cnt == CNT_W'(PERIOD - 1)) | force_start;
  assign xfer    = tx_valid & tx_ready;

  always_comb begin
    last_char = (char_idx == CI_W'(L - 1));
    last_ch   = (ch_idx == CH_W'(N_CH));
    nxt_ch    = ch_idx;
    nxt_ci    = char_idx + CI_W'(1);
    if (last_char) begin
      nxt_ch = ch_idx + CH_W'(1);
      nxt_ci = '0;
    end
  end

  // Free-running report period, independent of the frame state.
  always_ff @(posedge clk) begin
    if (rst)                                    period_cnt <= '0;
    else if (period_cnt == CNT_W'(PERIOD - 1))  period_cnt <= '0;
    else                                        period_cnt <= period_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pending    <= 1'b0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      snap       <= '0;
      ch_idx     <= CH_W'(1);
      char_idx   <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          // busy stays high through the frame_done cycle, drops here unless restarting
          if (trigger || pending) begin
            state   <= LOAD;
            busy    <= 1'b1;
            pending <= 1'b0;
          end else begin
            busy    <= 1'b0;
          end
        end
        LOAD: begin
          if (trigger) pending <= 1'b1;
          snap     <= ch_data;
          ch_idx   <= CH_W'(1);
          char_idx <= '0;
          tx_data  <= UNIT_CHAR;
          tx_valid <= 1'b1;
          state    <= SEND;
        end
        SEND: begin
          if (trigger) pending <= 1'b1;
          if (xfer) begin
            if (last_char && last_ch) begin
              tx_valid   <= 1'b0;
              frame_done <= 1'b1;
              state      <= IDLE;
            end else begin
              ch_idx   <= nxt_ch;
              char_idx <= nxt_ci;
              tx_data  <= line_char(nxt_ch, nxt_ci, snap);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
